// File: rtl/synthesis_primitives_pkg.sv
// Shared helpers for the one-hot to binary encoder tree: the node typedef
// macro and the stage-to-level split.
`ifndef SYNTH_NODE_T
`define SYNTH_NODE_T(name, IW) typedef struct packed { logic any; logic mul; logic [(IW)-1:0] idx; } name
`endif

package synthesis_primitives_pkg;

  // Last tree level (1-based) handled by stage k.
  function automatic int lvl_end(int k, int stages, int wl);
    return ((k + 1) * wl) / stages;
  endfunction

  function automatic int lvl_start(int k, int stages, int wl);
    return (k == 0) ? 1 : lvl_end(k - 1, stages, wl) + 1;
  endfunction

endpackage

// File: rtl/oht2bin_stage.sv
// One pipeline stage of the encoder: levels LVL_LO..LVL_HI of the OR-reduction
// tree plus its register and skid-free valid/ready handshake.
module oht2bin_stage #(
  parameter int IDX_W    = 5,
  parameter int LVL_LO   = 1,
  parameter int LVL_HI   = 5,
  parameter int NODES_IN = 32,
  parameter int RST_DATA = 0
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   in_vld,
  output logic                                                   in_rdy,
  input  logic [NODES_IN*(IDX_W+2)-1:0]                          in_nodes,
  output logic                                                   out_vld,
  input  logic                                                   out_rdy,
  output logic [(NODES_IN>>(LVL_HI-LVL_LO+1))*(IDX_W+2)-1:0]     out_nodes
);
  import synthesis_primitives_pkg::*;

  localparam int NL    = LVL_HI - LVL_LO + 1;
  localparam int NW    = IDX_W + 2;
  localparam int OUT_N = NODES_IN >> NL;
  localparam int TN    = 2 * NODES_IN - OUT_N;

  `SYNTH_NODE_T(node_t, IDX_W);

  node_t                 tree [TN];
  logic [OUT_N*NW-1:0]   nxt;

  // Nodes of local level j start at this offset in the flattened tree.
  function automatic int lvl_off(int j);
    return 2 * NODES_IN - 2 * (NODES_IN >> j);
  endfunction

  function automatic node_t combine(node_t l, node_t r, int lv);
    node_t n;
    n.any = l.any | r.any;
    n.idx = (r.any ? r.idx : l.idx) | (IDX_W'(r.any) << (lv - 1));
`ifdef OHT2BIN_PIPE_ERR_EN
    n.mul = l.mul | r.mul | (l.any & r.any);
`else
    n.mul = l.mul | r.mul;
`endif
    return n;
  endfunction

  always_comb begin
    tree = '{default: '0};
    nxt  = '0;
    for (int n = 0; n < NODES_IN; n++) tree[n] = in_nodes[n*NW +: NW];
    for (int j = 1; j <= NL; j++)
      for (int n = 0; n < (NODES_IN >> j); n++)
        tree[lvl_off(j)+n] = combine(tree[lvl_off(j-1)+2*n], tree[lvl_off(j-1)+2*n+1], LVL_LO+j-1);
    for (int n = 0; n < OUT_N; n++) nxt[n*NW +: NW] = tree[lvl_off(NL)+n];
  end

  // Stage register boundary
  assign in_rdy = !out_vld | out_rdy;

  always_ff @(posedge clk) begin
    if (rst) out_vld <= 1'b0;
    else if (in_rdy) out_vld <= in_vld;
  end

  always_ff @(posedge clk) begin
    if ((RST_DATA != 0) && rst) out_nodes <= '0;
    else if (in_rdy) out_nodes <= nxt;
  end

endmodule

// File: rtl/oht2bin_pipe.sv
// Pipelined one-hot to binary encoder with not-one-hot flag.
// Optional: define OHT2BIN_PIPE_ERR_EN to enable the err flag (else tied 0).
module oht2bin_pipe #(
  parameter  int WIDTH     = 32,
  parameter  int STAGES    = 1,
  localparam int WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_vld,
  output logic                 s_rdy,
  input  logic [WIDTH-1:0]     oht,
  output logic                 m_vld,
  input  logic                 m_rdy,
  output logic [WIDTH_LOG-1:0] bin,
  output logic                 err
);
  import synthesis_primitives_pkg::*;

  localparam int NPAD = 1 << WIDTH_LOG;
  localparam int NW   = WIDTH_LOG + 2;

  if ((STAGES < 1) || (STAGES > WIDTH_LOG)) begin : g_bad
    $fatal(1, "oht2bin_pipe: STAGES must be in 1..WIDTH_LOG");
  end

  `SYNTH_NODE_T(node_t, WIDTH_LOG);

  // Leaves: any = input bit, no partial index yet; padding bits stay zero.
  logic [NPAD*NW-1:0] leaves;
  always_comb begin
    leaves = '0;
    for (int i = 0; i < WIDTH; i++) leaves[i*NW + NW-1] = oht[i];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO    = lvl_start(k, STAGES, WIDTH_LOG);
    localparam int HI    = lvl_end(k, STAGES, WIDTH_LOG);
    localparam int IN_N  = NPAD >> (LO - 1);
    localparam int OUT_N = NPAD >> HI;

    logic                 in_vld, in_rdy, out_vld, out_rdy;
    logic [IN_N*NW-1:0]   in_nodes;
    logic [OUT_N*NW-1:0]  out_nodes;

    if (k == 0) begin : g_src
      assign in_vld   = s_vld;
      assign in_nodes = leaves;
    end else begin : g_src
      assign in_vld   = g_st[k-1].out_vld;
      assign in_nodes = g_st[k-1].out_nodes;
    end

    if (k == STAGES - 1) begin : g_dst
      assign out_rdy = m_rdy;
    end else begin : g_dst
      assign out_rdy = g_st[k+1].in_rdy;
    end

    oht2bin_stage #(
      .IDX_W    (WIDTH_LOG),
      .LVL_LO   (LO),
      .LVL_HI   (HI),
      .NODES_IN (IN_N),
      .RST_DATA ((k == STAGES - 1) ? 1 : 0)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_vld    (in_vld),
      .in_rdy    (in_rdy),
      .in_nodes  (in_nodes),
      .out_vld   (out_vld),
      .out_rdy   (out_rdy),
      .out_nodes (out_nodes)
    );
  end

  node_t last;
  assign last  = g_st[STAGES-1].out_nodes;
  assign s_rdy = g_st[0].in_rdy;
  assign m_vld = g_st[STAGES-1].out_vld;
  assign bin   = last.idx;

`ifdef OHT2BIN_PIPE_ERR_EN
  // Gated by m_vld so the reset value of the final register reads as no error.
  assign err = m_vld & (!last.any | last.mul);
`else
  logic unused_flags;
  assign unused_flags = last.any ^ last.mul;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_oht2bin_pipe.sv
// Bench for oht2bin_pipe: three configurations, each with a queue scoreboard
// and per-cycle compare against a highest-set-bit / popcount reference.
module tb_oht2bin_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef OHT2BIN_PIPE_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  typedef struct {
    int unsigned bin;
    bit          err;
    int          acc;
  } item_t;

  function automatic int unsigned ref_bin(logic [31:0] v);
    int unsigned r = 0;
    for (int i = 0; i < 32; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic bit ref_err(logic [31:0] v);
    return ERR_ON && ($countones(v) != 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_i
    localparam int W  = (g == 2) ? 5 : 8;
    localparam int S  = (g == 0) ? 3 : ((g == 1) ? 1 : 2);
    localparam int WL = $clog2(W);
    localparam logic [W-1:0] LV0 = (W == 8) ? W'(32'h20) : W'(32'h10);
    localparam int           EB0 = (W == 8) ? 5 : 4;
    localparam logic [W-1:0] LV1 = (W == 8) ? W'(32'h90) : W'(32'h03);
    localparam int           EB1 = (W == 8) ? 7 : 1;

    logic          rst   = 1'b1;
    logic          s_vld = 1'b0;
    logic          m_rdy = 1'b1;
    logic          s_rdy, m_vld, err;
    logic [W-1:0]  oht   = '0;
    logic [WL-1:0] bin;
    logic          done  = 1'b0;

    item_t q[$];
    int cyc = 0, last_low = 0, n_in = 0, n_out = 0;

    oht2bin_pipe #(.WIDTH(W), .STAGES(S)) dut (
      .clk   (clk),
      .rst   (rst),
      .s_vld (s_vld),
      .s_rdy (s_rdy),
      .oht   (oht),
      .m_vld (m_vld),
      .m_rdy (m_rdy),
      .bin   (bin),
      .err   (err)
    );

    function automatic string nm(string s);
      return $sformatf("i%0d.%s", g, s);
    endfunction

    initial begin : mon
      bit          prev_stall = 1'b0;
      logic [WL-1:0] prev_bin = '0;
      logic        prev_err = 1'b0;
      forever begin
        @(negedge clk);
        cyc++;
        if (rst || !m_rdy) last_low = cyc;
        if (rst) begin
          q.delete();
          n_in = 0;
          n_out = 0;
          prev_stall = 1'b0;
        end else begin
          if (prev_stall) begin
            check(nm("hold_vld"), int'(m_vld), 1);
            check(nm("hold_bin"), int'(bin), int'(prev_bin));
            check(nm("hold_err"), int'(err), int'(prev_err));
          end
          if (m_vld) begin
            if (q.size() == 0) begin
              check(nm("spurious_out"), int'(m_vld), 0);
            end else begin
              check(nm("bin"), int'(bin), int'(q[0].bin));
              check(nm("err"), int'(err), int'(q[0].err));
              if (m_rdy) begin
                if (last_low < q[0].acc) check(nm("latency"), cyc - q[0].acc, S);
                void'(q.pop_front());
                n_out++;
              end
            end
          end else if (q.size() != 0 && last_low < q[0].acc && cyc >= q[0].acc + S) begin
            check(nm("late_out"), int'(m_vld), 1);
          end
          if (s_vld && s_rdy) begin
            q.push_back('{ref_bin(32'(oht)), ref_err(32'(oht)), cyc});
            n_in++;
          end
          prev_stall = m_vld && !m_rdy;
          prev_bin   = bin;
          prev_err   = err;
        end
      end
    end

    task automatic send(input logic [W-1:0] v);
      int t = 0;
      s_vld = 1'b1;
      oht   = v;
      @(negedge clk);
      while (!s_rdy && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!s_rdy) check(nm("send_timeout"), int'(s_rdy), 1);
      @(posedge clk);
      #1;
      s_vld = 1'b0;
    endtask

    task automatic expect_lit(input logic [W-1:0] v, input int eb, input int ee, input string s);
      int t = 0;
      send(v);
      @(negedge clk);
      while (!m_vld && t < 20) begin
        @(negedge clk);
        t++;
      end
      check(nm({s, "_vld"}), int'(m_vld), 1);
      check(nm({s, "_bin"}), int'(bin), eb);
      check(nm({s, "_err"}), int'(err), ee);
      repeat (S + 2) @(posedge clk);
      #1;
    endtask

    initial begin : stim
      int acc;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check(nm("rst_m_vld"), int'(m_vld), 0);
      check(nm("rst_bin"), int'(bin), 0);
      check(nm("rst_err"), int'(err), 0);
      check(nm("rst_s_rdy"), int'(s_rdy), 1);
      @(posedge clk);
      #1;

      expect_lit(LV0, EB0, 0, "lit_onehot");
      expect_lit(LV1, EB1, int'(ERR_ON), "lit_multi");
      expect_lit('0, 0, int'(ERR_ON), "lit_zero");

      for (int i = 0; i < W; i++) send(W'(1) << i);
      repeat (S + 3) @(posedge clk);
      #1;
      check(nm("walk_count"), n_out, n_in);

      m_rdy = 1'b0;
      acc = 0;
      for (int c = 0; c < 5; c++) begin
        s_vld = (acc < 4);
        oht   = W'(1) << (acc % W);
        @(negedge clk);
        if (s_vld && s_rdy) acc++;
        @(posedge clk);
        #1;
      end
      check(nm("stall_accepted"), acc, S);
      check(nm("stall_s_rdy"), int'(s_rdy), 0);
      m_rdy = 1'b1;
      for (int c = 0; c < 20 && acc < 4; c++) begin
        s_vld = 1'b1;
        oht   = W'(1) << (acc % W);
        @(negedge clk);
        if (s_rdy) acc++;
        @(posedge clk);
        #1;
      end
      s_vld = 1'b0;
      check(nm("stall_all_sent"), acc, 4);
      repeat (S + 3) @(posedge clk);
      #1;
      check(nm("stall_drained"), q.size(), 0);
      check(nm("stall_count"), n_out, n_in);

      for (int c = 0; c < 400; c++) begin
        int r;
        r     = int'($urandom_range(0, 3));
        s_vld = ($urandom_range(0, 3) != 0);
        m_rdy = ($urandom_range(0, 3) != 0);
        case (r)
          0:       oht = '0;
          1:       oht = W'($urandom);
          default: oht = W'(1) << $urandom_range(0, W - 1);
        endcase
        @(posedge clk);
        #1;
      end
      s_vld = 1'b0;
      m_rdy = 1'b1;
      repeat (S + 3) @(posedge clk);
      #1;
      check(nm("rand_drained"), q.size(), 0);
      check(nm("rand_count"), n_out, n_in);

      m_rdy = 1'b0;
      s_vld = 1'b1;
      for (int c = 0; c < S + 2; c++) begin
        oht = W'(1) << (c % W);
        @(posedge clk);
        #1;
      end
      check(nm("prerst_full"), int'(m_vld), 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      s_vld = 1'b0;
      m_rdy = 1'b1;
      @(negedge clk);
      check(nm("midrst_m_vld"), int'(m_vld), 0);
      check(nm("midrst_bin"), int'(bin), 0);
      check(nm("midrst_err"), int'(err), 0);
      check(nm("midrst_s_rdy"), int'(s_rdy), 1);
      @(posedge clk);
      #1;
      send(W'(1) << 1);
      send(W'(1) << (W - 1));
      repeat (S + 3) @(posedge clk);
      #1;
      check(nm("postrst_out"), n_out, 2);
      check(nm("postrst_drained"), q.size(), 0);
      done = 1'b1;
    end
  end

  initial begin : main
    int t = 0;
    while (!(g_i[0].done && g_i[1].done && g_i[2].done) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 20000) check("global_timeout", t, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
